// File: rtl/dom_prng.sv
// dom_prng: fresh-randomness source for the masked AES datapath.
// A 64-bit LFSR is seeded over two 32-bit beats (high word first) and
// advanced W single steps per consumed word; r_out is state[W-1:0].
// Optional feature macro: DOM_PRNG_ZERO_GUARD_EN replaces an all-zero
// completed seed with 64'h1 so the LFSR cannot lock up.
module dom_prng #(
    parameter int unsigned W    = 32,
    parameter int unsigned WARM = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  seed_data,
    input  logic         seed_valid,
    output logic         seed_ready,
    input  logic         r_ready,
    output logic [W-1:0] r_out,
    output logic         r_valid
);

    localparam int unsigned CW = (WARM > 0) ? $clog2(WARM + 1) : 1;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        WARMUP   = 2'd2,
        RUN      = 2'd3
    } fsm_t;

    fsm_t          fsm, fsm_nxt;
    logic [63:0]   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [63:0]   seed_full;
    logic [63:0]   seed_load;

    // W single LFSR steps unrolled into one combinational advance
    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int unsigned i = 0; i < W; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    assign seed_full = {state[63:32], seed_data};

`ifdef DOM_PRNG_ZERO_GUARD_EN
    assign seed_load = (seed_full == '0) ? 64'h0000_0000_0000_0001 : seed_full;
`else
    assign seed_load = seed_full;
`endif

    // State register, FSM and warm-up counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= UNSEEDED;
            state <= '0;
            cnt   <= '0;
        end else begin
            fsm   <= fsm_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; a seed beat in RUN takes priority over an advance
    always_comb begin
        fsm_nxt   = fsm;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (fsm)
            UNSEEDED: begin
                if (seed_valid) begin
                    state_nxt = {seed_data, state[31:0]};
                    fsm_nxt   = LOAD;
                end
            end
            LOAD: begin
                if (seed_valid) begin
                    state_nxt = seed_load;
                    if (WARM > 0) begin
                        cnt_nxt = CW'(WARM);
                        fsm_nxt = WARMUP;
                    end else begin
                        fsm_nxt = RUN;
                    end
                end
            end
            WARMUP: begin
                state_nxt = advance(state);
                cnt_nxt   = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (seed_valid) begin
                    state_nxt = {seed_data, state[31:0]};
                    fsm_nxt   = LOAD;
                end else if (r_ready) begin
                    state_nxt = advance(state);
                end
            end
            default: fsm_nxt = UNSEEDED;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        seed_ready = (fsm != WARMUP);
        r_valid    = (fsm == RUN);
        r_out      = state[W-1:0];
    end

endmodule

// File: tb/tb_dom_prng.sv
// Self-checking bench for dom_prng: one instance with WARM=0 and one with
// WARM=16, a tap-mask LFSR model, and per-instance expected-word queues.
module tb_dom_prng;

    localparam int unsigned W = 32;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
`ifdef DOM_PRNG_ZERO_GUARD_EN
    localparam logic [31:0] ZERO_FIRST = 32'h1;
`else
    localparam logic [31:0] ZERO_FIRST = 32'h0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  sdata  [2];
    logic         svalid [2];
    logic         rready [2];
    logic         sready [2];
    logic [W-1:0] rout   [2];
    logic         rvalid [2];
    logic         mon_en [2];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    dom_prng #(.W(W), .WARM(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .seed_data(sdata[0]), .seed_valid(svalid[0]), .seed_ready(sready[0]),
        .r_ready(rready[0]), .r_out(rout[0]), .r_valid(rvalid[0])
    );

    dom_prng #(.W(W), .WARM(16)) u_dut_w16 (
        .clk(clk), .rst_n(rst_n),
        .seed_data(sdata[1]), .seed_valid(svalid[1]), .seed_ready(sready[1]),
        .r_ready(rready[1]), .r_out(rout[1]), .r_valid(rvalid[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_adv(input logic [63:0] s, input int unsigned n);
        logic [63:0] t;
        logic        fb;
        t = s;
        for (int unsigned i = 0; i < n; i++) begin
            fb = ^(t & TAPS);
            t  = (t << 1) | {63'd0, fb};
        end
        return t;
    endfunction

    function automatic logic [63:0] seed_model(input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] s;
        s = {hi, lo};
`ifdef DOM_PRNG_ZERO_GUARD_EN
        if (s == 64'd0) s = 64'd1;
`endif
        return s;
    endfunction

    // Scoreboard side: every valid cycle in a monitored window pops one word
    always @(negedge clk) begin
        if (mon_en[0]) begin
            check_eq("w0_valid_held", {63'd0, rvalid[0]}, 64'd1);
            if (exp_q0.size() == 0) check_eq("w0_q_underflow", 64'd1, 64'd0);
            else check_eq("w0_word", {32'd0, rout[0]}, {32'd0, exp_q0.pop_front()});
        end
        if (mon_en[1]) begin
            check_eq("w16_valid_held", {63'd0, rvalid[1]}, 64'd1);
            if (exp_q1.size() == 0) check_eq("w16_q_underflow", 64'd1, 64'd0);
            else check_eq("w16_word", {32'd0, rout[1]}, {32'd0, exp_q1.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [W-1:0] v);
        if (idx == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endtask

    task automatic send_seed(input int idx, input logic [31:0] hi, input logic [31:0] lo);
        svalid[idx] = 1'b1;
        sdata[idx]  = hi;
        tick();
        sdata[idx]  = lo;
        tick();
        svalid[idx] = 1'b0;
        sdata[idx]  = '0;
    endtask

    // Drive r_ready per pat bit, pushing the expected word for each cycle
    task automatic run_words(input int idx, input logic [63:0] m_in, input int unsigned n,
                             input logic [31:0] pat, output logic [63:0] m_out);
        logic [63:0] m;
        int          left;
        m = m_in;
        mon_en[idx] = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            push(idx, m[W-1:0]);
            rready[idx] = pat[i];
            tick();
            if (pat[i]) m = model_adv(m, W);
        end
        rready[idx] = 1'b0;
        mon_en[idx] = 1'b0;
        left = (idx == 0) ? exp_q0.size() : exp_q1.size();
        check_eq("q_drained", 64'(left), 64'd0);
        m_out = m;
    endtask

    task automatic wait_valid(input int idx, output int cycles, output logic sready_seen);
        cycles      = 0;
        sready_seen = 1'b0;
        while (!rvalid[idx] && cycles < 100) begin
            if (sready[idx]) sready_seen = 1'b1;
            tick();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        logic [63:0] m0;
        int          cyc;
        logic        seen;
        logic        early;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sdata[i] = '0; svalid[i] = 1'b0; rready[i] = 1'b0; mon_en[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_valid", {63'd0, rvalid[i]}, 64'd0);
            check_eq("rst_rout", {32'd0, rout[i]}, 64'd0);
            check_eq("rst_sready", {63'd0, sready[i]}, 64'd1);
        end
        #1 rst_n = 1'b1;
        tick();

        // Seed 0x00000000_00000001, first word then first advance
        send_seed(0, 32'h0000_0000, 32'h0000_0001);
        check_eq("t1_valid_rise", {63'd0, rvalid[0]}, 64'd1);
        check_eq("t1_first", {32'd0, rout[0]}, 64'h1);
        run_words(0, seed_model(32'h0, 32'h1), 3, 32'b111, m);

        // Stall for 5 cycles, then resume
        send_seed(0, 32'h0000_0000, 32'h0000_0001);
        run_words(0, seed_model(32'h0, 32'h1), 7, 32'b1100000, m);

        // Warm-up of 16 advances
        send_seed(1, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid(1, cyc, seen);
        check_eq("t3_warm_cycles", 64'(cyc), 64'd16);
        check_eq("t3_sready_low", {63'd0, seen}, 64'd0);
        m = model_adv(seed_model(32'h1234_5678, 32'h9ABC_DEF0), 16 * W);
        check_eq("t3_first", {32'd0, rout[1]}, {32'd0, m[W-1:0]});
        run_words(1, m, 5, 32'b10111, m);

        // Reseed in RUN with r_ready high in the same cycle
        send_seed(0, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        run_words(0, seed_model(32'hCAFE_F00D, 32'h0BAD_BEEF), 3, 32'b111, m0);
        mon_en[0] = 1'b1;
        push(0, m0[W-1:0]);
        svalid[0] = 1'b1;
        sdata[0]  = 32'hA5A5_0F0F;
        rready[0] = 1'b1;
        tick();
        mon_en[0] = 1'b0;
        rready[0] = 1'b0;
        check_eq("t4_valid_drop", {63'd0, rvalid[0]}, 64'd0);
        check_eq("t4_no_advance", {32'd0, rout[0]}, {32'd0, m0[W-1:0]});
        sdata[0] = 32'h1357_9BDF;
        tick();
        svalid[0] = 1'b0;
        check_eq("t4_valid_back", {63'd0, rvalid[0]}, 64'd1);
        run_words(0, seed_model(32'hA5A5_0F0F, 32'h1357_9BDF), 3, 32'b111, m);

        // All-zero seed
        send_seed(0, 32'h0, 32'h0);
        check_eq("t5_first", {32'd0, rout[0]}, {32'd0, ZERO_FIRST});
        run_words(0, seed_model(32'h0, 32'h0), 4, 32'b1111, m);

        // Asynchronous reset in the middle of warm-up
        send_seed(1, 32'h0F1E_2D3C, 32'h4B5A_6978);
        tick();
        tick();
        tick();
        check_eq("t6_in_warmup", {63'd0, rvalid[1]}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", {63'd0, rvalid[1]}, 64'd0);
        check_eq("t6_rst_rout", {32'd0, rout[1]}, 64'd0);
        check_eq("t6_rst_sready", {63'd0, sready[1]}, 64'd1);
        check_eq("t6_rst_w0_valid", {63'd0, rvalid[0]}, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        svalid[1] = 1'b1;
        sdata[1]  = 32'h7777_0001;
        tick();
        svalid[1] = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid[1]) early = 1'b1;
            tick();
        end
        check_eq("t6_one_beat_not_valid", {63'd0, early}, 64'd0);
        svalid[1] = 1'b1;
        sdata[1]  = 32'h8888_0002;
        tick();
        svalid[1] = 1'b0;
        wait_valid(1, cyc, seen);
        check_eq("t6_warm_cycles", 64'(cyc), 64'd16);
        m = model_adv(seed_model(32'h7777_0001, 32'h8888_0002), 16 * W);
        run_words(1, m, 3, 32'b111, m);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dom_prng.md
# dom_prng

Fresh-randomness source for the masked round-based AES datapath. Expands a 64-bit seed, delivered over a 32-bit handshake, into `W` fresh random bits per cycle using a W-step unrolled 64-bit LFSR. It sits directly upstream of the first-order DOM AND gadgets and drives their `r` inputs. The bits are refreshed only when the datapath consumes them, so each gadget evaluation gets a distinct mask.

## Interface
- `W`, 32: random bits delivered per advance; legal range 1..64.
- `WARM`, 16: number of discard advances after seeding; 0 means no warm-up.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seed_data` in 32: seed beat. First beat is `state[63:32]`, second is `state[31:0]`.
- `seed_valid` in 1: seed beat offered.
- `seed_ready` out 1: seed beat accepted when `seed_valid && seed_ready`.
- `r_ready` in 1: consumer took the current `r_out`; the state advances.
- `r_out` out W: fresh randomness, equal to `state[W-1:0]`.
- `r_valid` out 1: `r_out` is fresh and usable.

## Operation
- **State:** 64-bit `state` and a 2-bit FSM.
  - FSM states: UNSEEDED, LOAD, WARMUP, RUN.
  - Warm-up counter width: clog2(WARM+1).
- **LFSR single step:** `state <= {state[62:0], state[63]^state[62]^state[60]^state[59]}`. One advance applies W single steps combinationally.
- **UNSEEDED:** `seed_ready`=1, `r_valid`=0. An accepted beat loads `state[63:32]` and moves to LOAD.
- **LOAD:** `seed_ready`=1, `r_valid`=0. An accepted beat loads `state[31:0]`.
  - WARM>0: go to WARMUP with counter=WARM.
  - WARM=0: go to RUN.
- **WARMUP:** `seed_ready`=0, `r_valid`=0.
  - Advance every cycle and decrement the counter.
  - On the cycle the counter reaches 1, go to RUN.
- **RUN:** `r_valid`=1, `seed_ready`=1.
  - `r_ready`=1: advance.
  - `r_ready`=0: hold the state; `r_out` is stable.
- **Reseed from RUN:** an accepted beat in RUN loads `state[63:32]` and goes to LOAD. `r_valid` drops the next cycle.
  - If `seed_valid` and `r_ready` are high in the same RUN cycle, the seed wins and no advance happens.
  - Consumers must not use `r_out` while `r_valid`=0.
- **Outputs:** `r_out`, `r_valid` and `seed_ready` are decoded from registered state only, with no input-to-output combinational path.
- **Reset:** asynchronous `rst_n`=0, including mid-warm-up or mid-load, forces:
  - `state`=0, FSM=UNSEEDED, counter=0;
  - `r_out`=0, `r_valid`=0, `seed_ready`=1.

## Timing
- First beat accepted at edge t, second beat accepted at edge t+1 or later (call it edge s).
- WARM=0: `r_valid`=1 in the cycle after edge s. `r_out` is the seed's low W bits.
- WARM>0: `r_valid`=1 after WARM further edges. `r_out` is the seed advanced WARM times.
- Throughput in RUN: one fresh W-bit word per cycle while `r_ready`=1.
- Advance is visible on `r_out` in the cycle after `r_ready` is sampled high.

## Configuration
- Macro `DOM_PRNG_ZERO_GUARD_EN` controls handling of an all-zero seed.
  - Defined: if the completed 64-bit seed is all-zero, `state` is loaded with 64'h0000_0000_0000_0001 instead.
  - Undefined: the seed is loaded verbatim. An all-zero seed locks the LFSR and `r_out` stays 0. Integration then guarantees a nonzero seed.

## Test plan
- **Seed and first advance:** W=32, WARM=0. Send beats 0x00000000 then 0x00000001, hold `r_ready`=1.
  - Required: `r_valid` rises the next cycle with `r_out`=0x00000001.
  - Next cycle `r_out`=0x00000000, because `state`=0x00000001_00000000 and no tap is set yet.
- **Stall:** same seed, hold `r_ready`=0 for 5 RUN cycles.
  - Required: `r_out` stays 0x00000001 and `r_valid` stays 1.
  - Resume `r_ready`=1: the next value is 0x00000000.
- **Warm-up:** WARM=16, any nonzero seed.
  - Required: `r_valid` stays 0 and `seed_ready` stays 0 for exactly 16 cycles.
  - The first `r_out` equals the golden model after 16 advances.
- **Reseed in RUN:** assert `seed_valid` and `r_ready` in the same RUN cycle.
  - Required: `r_valid` drops the next cycle and the state does not advance.
  - After the second beat, output restarts from the new seed.
- **Zero seed:** beats 0, 0, WARM=0.
  - With `DOM_PRNG_ZERO_GUARD_EN`: `r_out`=0x00000001, then 0x00000000.
  - Without the macro: `r_out`=0 on every cycle.
- **Asynchronous reset:** pulse `rst_n` low mid-WARMUP, between clock edges.
  - Required: outputs go to reset values immediately: `r_valid`=0, `r_out`=0, `seed_ready`=1, FSM=UNSEEDED.
  - A full two-beat reseed is then required before `r_valid` rises.
